// File: rtl/uart_wb_bridge.sv
// uart_wb_bridge: turns framed UART command bytes into single 32-bit
// Wishbone read/write cycles and streams the response bytes back.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a command byte ('W' or 'R'); anything else -> 'E'
// ADDR  | shifting in A3..A0, frame idle timer running
// DATA  | shifting in D3..D0 (write only), frame idle timer running
// BUS   | Wishbone cycle in flight, ack timer running
// RESP  | presenting response bytes on tx until the last is accepted
module uart_wb_bridge #(
  parameter int ACK_TIMEOUT   = 1024,
  parameter int FRAME_TIMEOUT = 400000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  output logic        busy,
  output logic        err,
  output logic        rx_drop
);

  localparam logic [7:0] CMD_W  = 8'h57;
  localparam logic [7:0] CMD_R  = 8'h52;
  localparam logic [7:0] RSP_OK = 8'h4B;
  localparam logic [7:0] RSP_E  = 8'h45;

  // One down-counter serves both timeouts since ADDR/DATA and BUS never overlap.
  localparam int TMAX = (FRAME_TIMEOUT > ACK_TIMEOUT) ? FRAME_TIMEOUT : ACK_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] FT_LOAD = TW'(FRAME_TIMEOUT - 1);
  localparam logic [TW-1:0] AT_LOAD = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP} state_t;

  state_t         state;
  logic [1:0]     cnt;
  logic [1:0]     last;
  logic           we;
  logic [31:0]    resp_word;
  logic [TW-1:0]  tmr;

  // busy is a pure state decode
  assign busy = (state != IDLE);

  // Frame parser, bus initiator and response sequencer
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      cnt       <= '0;
      last      <= '0;
      we        <= 1'b0;
      resp_word <= '0;
      tmr       <= '0;
      tx_data   <= '0;
      tx_valid  <= 1'b0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= '0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      err       <= 1'b0;
      rx_drop   <= 1'b0;
    end else begin
      err     <= 1'b0;
      rx_drop <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_valid) begin
            cnt <= '0;
            if (rx_data == CMD_W || rx_data == CMD_R) begin
              we    <= (rx_data == CMD_W);
              tmr   <= FT_LOAD;
              state <= ADDR;
            end else begin
              err      <= 1'b1;
              tx_data  <= RSP_E;
              tx_valid <= 1'b1;
              last     <= 2'd0;
              state    <= RESP;
            end
          end
        end
        ADDR, DATA: begin
          if (rx_valid) begin
            tmr <= FT_LOAD;
            cnt <= cnt + 2'd1;
            if (state == ADDR) wbm_adr_o <= {wbm_adr_o[23:0], rx_data};
            else               wbm_dat_o <= {wbm_dat_o[23:0], rx_data};
            if (cnt == 2'd3) begin
              cnt <= '0;
              if (state == ADDR && we) begin
                state <= DATA;
              end else begin
                wbm_cyc_o <= 1'b1;
                wbm_stb_o <= 1'b1;
                wbm_we_o  <= we;
                wbm_sel_o <= 4'hF;
                tmr       <= AT_LOAD;
                state     <= BUS;
              end
            end
          end else if (tmr == '0) begin
            // abandoned frame: drop it without any response
            state <= IDLE;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        BUS: begin
          if (rx_valid) rx_drop <= 1'b1;
          // ack is checked first so a last-cycle ack still completes normally
          if (wbm_ack_i || tmr == '0) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= '0;
            tx_valid  <= 1'b1;
            cnt       <= '0;
            last      <= 2'd0;
            state     <= RESP;
            if (!wbm_ack_i) begin
              err     <= 1'b1;
              tx_data <= RSP_E;
            end else if (wbm_we_o) begin
              tx_data <= RSP_OK;
            end else begin
              resp_word <= wbm_dat_i;
              tx_data   <= wbm_dat_i[31:24];
              last      <= 2'd3;
            end
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        RESP: begin
          if (rx_valid) rx_drop <= 1'b1;
          if (tx_ready) begin
            if (cnt == last) begin
              tx_valid <= 1'b0;
              state    <= IDLE;
            end else begin
              cnt       <= cnt + 2'd1;
              tx_data   <= resp_word[23:16];
              resp_word <= resp_word << 8;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
